// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory over req/ack,
// and hands each fetched word to the decoder over a valid/ready interface.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc_out,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [15:0] fetch_count,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;

  // Handshakes: a memory read completes on any cycle with imem_req & imem_ack;
  // an instruction transfers on any cycle with instr_valid & instr_ready.
  // req/valid never depend combinationally on ack/ready, and the address and
  // instruction stay frozen until their handshake completes.
  assign imem_addr = pc;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instruction <= NOP_WORD;
      pc_out      <= RESET_PC;
      fetch_count <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            instruction <= imem_rdata;
            pc_out      <= pc;
            pc          <= pc + 32'd4;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            // pc already points at pc_out+4; only a taken branch overrides it
            if (branch_taken) begin
              pc <= branch_target & 32'hFFFF_FFFC;
            end
            fetch_count <= fetch_count + 16'd1;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= FETCH;
          end
        end
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
